// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time from imem,
// hands it to the IDU, then waits for the downstream next-PC before fetching again.
module ifu #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
    input  logic             clk,
    input  logic             rst,

    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    output logic             imem_rsp_ready,
    input  logic [31:0]      imem_rsp_data,
    input  logic             imem_rsp_err,

    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_fault,

    input  logic             next_pc_valid,
    input  logic [WIDTH-1:0] next_pc,

    output logic [31:0]      fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ      = 2'd0,
        S_WAIT_RSP = 2'd1,
        S_HOLD     = 2'd2,
        S_WAIT_NPC = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic             inst_fault_q, inst_fault_d;
    logic             inst_valid_q, inst_valid_d;
    logic [31:0]      fetch_cnt_q, fetch_cnt_d;

    logic             inst_hs;
    logic             take_npc;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        inst_valid_d = inst_valid_q;
        fetch_cnt_d  = fetch_cnt_q;

        inst_hs  = (state_q == S_HOLD) && inst_ready;
        // A next PC is only meaningful once the current instruction has left the IFU.
        take_npc = next_pc_valid && (inst_hs || (state_q == S_WAIT_NPC));

        case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (imem_rsp_valid) begin
                    inst_d       = imem_rsp_err ? 32'h0 : imem_rsp_data;
                    inst_fault_d = imem_rsp_err;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    fetch_cnt_d  = fetch_cnt_q + 32'd1;
                    state_d      = S_WAIT_NPC;
                end
            end
            S_WAIT_NPC: begin
                state_d = S_WAIT_NPC;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Misaligned targets never reach memory; they come back as a faulting instruction.
        if (take_npc) begin
            pc_d = next_pc;
            if (next_pc[1:0] == 2'b00) begin
                state_d = S_REQ;
            end else begin
                inst_d       = 32'h0;
                inst_fault_d = 1'b1;
                inst_pc_d    = next_pc;
                inst_valid_d = 1'b1;
                state_d      = S_HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
            inst_valid_q <= 1'b0;
            fetch_cnt_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
            inst_valid_q <= inst_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    // Bus handshakes are suppressed during reset so no transfer can start on a reset cycle.
    assign imem_req_valid = !rst && (state_q == S_REQ);
    assign imem_rsp_ready = !rst && (state_q == S_WAIT_RSP);
    assign imem_req_addr  = pc_q;

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed and randomized instruction lifecycles checked against a
// transaction-level model of PC flow, memory contents and the handed-off instruction count.
module tb_ifu;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        next_pc_valid;
    logic [31:0] next_pc;
    logic [31:0] fetch_cnt;

    ifu #(.WIDTH(32), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_ready (imem_rsp_ready),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .next_pc_valid  (next_pc_valid),
        .next_pc        (next_pc),
        .fetch_cnt      (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] rnd_npc;
    int          sel;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RPC) return 32'h0000_0413;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[6:4] == 3'b111;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One instruction lifecycle starting from the model PC; ends with the next PC applied.
    task automatic run_inst(input int req_wait, input int rsp_wait, input int idu_wait,
                            input int npc_wait, input logic [31:0] npc, input bit preload);
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_fault;
        if (m_pc[1:0] == 2'b00) begin
            for (int i = 0; i < req_wait; i++) begin
                imem_req_ready = 1'b0;
                next_pc_valid  = 1'($urandom_range(0, 1));
                next_pc        = $urandom;
                #1;
                chk("req_valid_wait", 32'(imem_req_valid), 32'd1);
                chk("req_addr_wait", imem_req_addr, m_pc);
                chk("inst_valid_req", 32'(inst_valid), 32'd0);
                @(negedge clk);
            end
            imem_req_ready = 1'b1;
            next_pc_valid  = 1'b0;
            #1;
            chk("req_valid_hs", 32'(imem_req_valid), 32'd1);
            chk("req_addr_hs", imem_req_addr, m_pc);
            @(negedge clk);
            imem_req_ready = 1'b0;
            for (int i = 0; i < rsp_wait; i++) begin
                imem_rsp_valid = 1'b0;
                next_pc_valid  = 1'($urandom_range(0, 1));
                next_pc        = $urandom;
                #1;
                chk("rsp_ready_wait", 32'(imem_rsp_ready), 32'd1);
                chk("req_valid_in_rsp", 32'(imem_req_valid), 32'd0);
                @(negedge clk);
            end
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(m_pc);
            imem_rsp_err   = mem_err(m_pc);
            next_pc_valid  = 1'b0;
            #1;
            chk("rsp_ready_hs", 32'(imem_rsp_ready), 32'd1);
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = 1'($urandom_range(0, 1));
            e_fault = mem_err(m_pc);
            e_inst  = e_fault ? 32'h0 : mem_word(m_pc);
        end else begin
            e_fault = 1'b1;
            e_inst  = 32'h0;
        end
        e_pc = m_pc;

        for (int i = 0; i < idu_wait; i++) begin
            inst_ready    = 1'b0;
            next_pc_valid = 1'($urandom_range(0, 1));
            next_pc       = $urandom;
            if (preload && i == 0) force dut.fetch_cnt_d = 32'hFFFF_FFFF;
            #1;
            chk("inst_valid_hold", 32'(inst_valid), 32'd1);
            chk("inst_hold", inst, e_inst);
            chk("inst_pc_hold", inst_pc, e_pc);
            chk("inst_fault_hold", 32'(inst_fault), 32'(e_fault));
            chk("req_valid_hold", 32'(imem_req_valid), 32'd0);
            chk("fetch_cnt_hold", fetch_cnt, m_cnt);
            @(negedge clk);
            if (preload && i == 0) begin
                release dut.fetch_cnt_d;
                m_cnt = 32'hFFFF_FFFF;
            end
        end
        inst_ready    = 1'b1;
        next_pc       = npc;
        next_pc_valid = (npc_wait == 0);
        #1;
        chk("inst_valid_hs", 32'(inst_valid), 32'd1);
        chk("inst_hs", inst, e_inst);
        chk("inst_pc_hs", inst_pc, e_pc);
        chk("inst_fault_hs", 32'(inst_fault), 32'(e_fault));
        @(negedge clk);
        inst_ready    = 1'b0;
        next_pc_valid = 1'b0;
        m_cnt         = m_cnt + 32'd1;
        #1;
        chk("fetch_cnt_inc", fetch_cnt, m_cnt);
        if (npc_wait > 0) begin
            for (int i = 0; i < npc_wait; i++) begin
                #1;
                chk("inst_valid_npc", 32'(inst_valid), 32'd0);
                chk("req_valid_npc", 32'(imem_req_valid), 32'd0);
                @(negedge clk);
            end
            next_pc       = npc;
            next_pc_valid = 1'b1;
            @(negedge clk);
            next_pc_valid = 1'b0;
        end
        m_pc = npc;
        #1;
        if (npc[1:0] == 2'b00) begin
            chk("next_req_valid", 32'(imem_req_valid), 32'd1);
            chk("next_req_addr", imem_req_addr, npc);
            chk("next_inst_valid", 32'(inst_valid), 32'd0);
        end else begin
            chk("mis_inst_valid", 32'(inst_valid), 32'd1);
            chk("mis_inst", inst, 32'h0);
            chk("mis_fault", 32'(inst_fault), 32'd1);
            chk("mis_inst_pc", inst_pc, npc);
            chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
        end
    endtask

    // Reset lands in WAIT_RSP together with a response that must be dropped.
    task automatic reset_mid_rsp();
        imem_req_ready = 1'b1;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst            = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        imem_rsp_err   = 1'b0;
        #1;
        chk("rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
        chk("rst_req_gated", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        rst            = 1'b0;
        imem_rsp_valid = 1'b0;
        m_pc           = RPC;
        m_cnt          = 32'h0;
        #1;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_req_after", 32'(imem_req_valid), 32'd1);
        chk("rst_addr_after", imem_req_addr, RPC);
        chk("rst_cnt_after", fetch_cnt, 32'h0);
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        next_pc_valid  = 1'b0;
        next_pc        = 32'h0;
        m_pc           = RPC;
        m_cnt          = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
        chk("reset_rsp_ready", 32'(imem_rsp_ready), 32'd0);
        chk("reset_inst_valid", 32'(inst_valid), 32'd0);
        chk("reset_inst", inst, 32'h0);
        chk("reset_inst_pc", inst_pc, 32'h0);
        chk("reset_fault", 32'(inst_fault), 32'd0);
        chk("reset_cnt", fetch_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, RPC);

        run_inst(0, 0, 0, 0, RPC + 32'd4, 1'b0);
        run_inst(3, 2, 4, 0, 32'h8000_0070, 1'b0);
        run_inst(0, 1, 1, 2, 32'h8000_0102, 1'b0);
        run_inst(0, 0, 2, 0, 32'h8000_0200, 1'b0);
        run_inst(1, 0, 3, 0, 32'h8000_0204, 1'b1);
        reset_mid_rsp();

        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      rnd_npc = {m_pc[31:2], 2'b00} + 32'd4;
            else if (sel < 9) rnd_npc = {16'h8000, 14'($urandom), 2'b00};
            else              rnd_npc = {16'h8000, 14'($urandom), 2'($urandom_range(1, 3))};
            run_inst(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), rnd_npc, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the NPC core: owns the architectural PC, fetches one instruction at a time from instruction memory over a valid/ready request/response bus, and hands the instruction and its PC to the IDU over a valid/ready channel. It then waits for the next-PC value computed downstream (branch/jump/PC+4) before issuing the next fetch. One instruction is in flight at a time; there is no prefetch or speculation.

## Interface
Parameters:
- WIDTH, 32, data/address width
- RESET_PC, 32'h80000000, first fetch address after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  WIDTH  fetch address, word-aligned
- imem_rsp_valid  in  1  response valid
- imem_rsp_ready  out  1  IFU accepts response
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault for this response
- inst_valid  out  1  instruction available to IDU
- inst_ready  in  1  IDU consumes instruction
- inst  out  32  instruction word
- inst_pc  out  WIDTH  PC of inst
- inst_fault  out  1  inst is invalid (access fault or misaligned PC); inst forced to 0
- next_pc_valid  in  1  next PC from EXU/WB is valid
- next_pc  in  WIDTH  next PC value
- fetch_cnt  out  32  count of instructions handed to IDU

## Operation
- States: REQ, WAIT_RSP, HOLD, WAIT_NPC.
- Reset (rst=1 at edge): state<=REQ, pc<=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_fault=0, fetch_cnt=0. imem_req_valid and imem_rsp_ready are 0 while rst is high.
- REQ: imem_req_valid=1, imem_req_addr=pc, held stable until accepted. On valid&&ready -> WAIT_RSP.
- WAIT_RSP: imem_rsp_ready=1. On rsp_valid: inst<=err?0:rsp_data, inst_fault<=err, inst_pc<=pc, inst_valid<=1 -> HOLD. Responses outside WAIT_RSP are not accepted (rsp_ready=0).
- HOLD: inst, inst_pc, inst_fault stable while inst_valid=1 and inst_ready=0. On inst_valid&&inst_ready: inst_valid<=0, fetch_cnt<=fetch_cnt+1 (wraps at 2^32-1 -> 0); if next_pc_valid same cycle, take it as in WAIT_NPC directly, else -> WAIT_NPC.
- WAIT_NPC: on next_pc_valid: pc<=next_pc. If next_pc[1:0]==0 -> REQ. If misaligned: no memory request; inst<=0, inst_fault<=1, inst_pc<=next_pc, inst_valid<=1 -> HOLD.
- next_pc_valid is ignored in REQ and WAIT_RSP, and in HOLD unless the inst handshake occurs that cycle.
- Fault is only reported; IFU does not stop. Trap handling redirects via next_pc.
- Reset mid-operation (any state): returns to REQ with RESET_PC next cycle; any outstanding memory response is abandoned (memory shares rst and drops it).

## Timing
- All outputs registered or decoded from state register only; no combinational path from imem_rsp_* or next_pc_* to imem_req_*, inst_*.
- Best case with zero-wait memory: cycle 0 req accepted, cycle 1 rsp accepted, cycle 2 inst_valid=1; if inst_ready and next_pc_valid both high in cycle 2, cycle 3 new req. Steady-state throughput 1 instruction per 3 cycles.
- Memory wait states add cycles 1:1 in REQ (ready low) and WAIT_RSP (rsp_valid low).
- First request after reset release: imem_req_valid=1 in first cycle with rst=0, addr=RESET_PC.
- Misaligned next_pc: inst_valid=1 one cycle after next_pc_valid, zero memory traffic.

## Test plan
- Reset release, zero-wait memory returning 0x00000413 at 0x80000000 -> req addr 0x80000000 in cycle 0, inst_valid cycle 2 with inst=0x00000413, inst_pc=0x80000000, fetch_cnt 0->1 on handshake.
- Same-cycle handshake: inst_ready=1 and next_pc=0x80000004 valid in HOLD -> next cycle req_addr=0x80000004; next_pc_valid pulsed in REQ/WAIT_RSP -> ignored, pc unchanged.
- Backpressure: req_ready low 3 cycles, rsp 2 cycles late, inst_ready low 4 cycles -> req_addr/inst/inst_pc stable throughout, exactly one req and one rsp handshake.
- Faults: rsp_err=1 -> inst=0, inst_fault=1; next_pc=0x80000102 -> no req_valid, inst_fault=1, inst_pc=0x80000102 one cycle later.
- Reset asserted in WAIT_RSP with response arriving same cycle -> response not latched, inst_valid=0, next cycle req_addr=RESET_PC.
- fetch_cnt preloaded near wrap (force 0xFFFFFFFF via 2^32 fetches shortened by forcing) -> one handshake gives 0x00000000.
